// File: rtl/receptor_ascii.sv
`default_nettype none
// ============================================================================
//  Module      : receptor_ascii
//  Description : 7E2 serial receiver (idle high, LSB first) that assembles
//                received ASCII characters into a message buffer. A message
//                ends on the terminator character or when the buffer fills,
//                after which pronto is held until limpa or reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module receptor_ascii #(
   parameter int         CICLOS_BIT = 434,     // clocks per bit, >= 4
   parameter int         N_CHARS    = 8,       // buffer depth, 2..8
   parameter logic [6:0] TERMINADOR = 7'h23    // '#'
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   entrada_serial,
   input  logic                   limpa,
   output logic [7*N_CHARS-1:0]   dados_ascii,
   output logic [3:0]             num_caracteres,
   output logic                   pronto,
   output logic                   erro_paridade,
   output logic                   erro_parada,
   output logic [3:0]             db_estado
);

   // ------------------------------------------------------------------------
   // Constants
   // ------------------------------------------------------------------------
   localparam int c_CW = (CICLOS_BIT > 2) ? $clog2(CICLOS_BIT) : 1;

   localparam logic [c_CW-1:0] c_MEIO   = c_CW'(CICLOS_BIT / 2);
   localparam logic [c_CW-1:0] c_ULTIMO = c_CW'(CICLOS_BIT - 1);
   localparam logic [3:0]      c_NCHARS = 4'(N_CHARS);

   // FSM state codes (also exported on db_estado)
   localparam logic [3:0] c_ESPERA   = 4'd0;
   localparam logic [3:0] c_INICIO   = 4'd1;
   localparam logic [3:0] c_RECEBE   = 4'd2;
   localparam logic [3:0] c_CHECA    = 4'd3;
   localparam logic [3:0] c_ARMAZENA = 4'd4;
   localparam logic [3:0] c_DESCARTA = 4'd5;
   localparam logic [3:0] c_FIM      = 4'd6;

   // ------------------------------------------------------------------------
   // Declarations
   // ------------------------------------------------------------------------
   logic                  sync1_q;
   logic                  sync2_q;
   logic                  ant_q;

   logic [3:0]            estado_q, estado_d;

   logic [c_CW-1:0]       cnt_q, cnt_d;
   logic [3:0]            nbits_q, nbits_d;
   logic [8:0]            desloc_q, desloc_d;

   logic [7*N_CHARS-1:0]  dados_q, dados_d;
   logic [3:0]            num_q, num_d;
   logic                  perr_q, perr_d;
   logic                  serr_q, serr_d;

   logic                  w_borda;
   logic                  w_meio;
   logic                  w_fim_bit;
   logic                  w_err_par;
   logic                  w_err_stop;
   logic                  w_term;
   logic                  w_cheio;

   // ------------------------------------------------------------------------
   // Decoded conditions
   // ------------------------------------------------------------------------
   // Falling edge on the synchronized line marks a candidate start bit.
   assign w_borda    = ant_q & ~sync2_q;
   assign w_meio     = (cnt_q == c_MEIO);
   assign w_fim_bit  = (cnt_q == c_ULTIMO);
   // desloc_q after nine samples: [6:0] data, [7] parity, [8] first stop.
   assign w_err_par  = ^desloc_q[7:0];
   assign w_err_stop = ~desloc_q[8];
   assign w_term     = (desloc_q[6:0] == TERMINADOR);
   assign w_cheio    = ((num_q + 4'd1) == c_NCHARS);

   // ------------------------------------------------------------------------
   // Input synchronizer and edge history; only reset re-initializes it
   // ------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         ant_q   <= 1'b1;
      end else begin
         sync1_q <= entrada_serial;
         sync2_q <= sync1_q;
         ant_q   <= sync2_q;
      end
   end

   // ------------------------------------------------------------------------
   // FSM state register; limpa re-arms exactly like reset
   // ------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset || limpa) begin
         estado_q <= c_ESPERA;
      end else begin
         estado_q <= estado_d;
      end
   end

   // ------------------------------------------------------------------------
   // FSM next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      estado_d = estado_q;
      case (estado_q)
         c_ESPERA: begin
            if (w_borda) begin
               estado_d = c_INICIO;
            end
         end
         c_INICIO: begin
            // Line back high at mid start bit means a glitch: drop silently.
            if (w_meio) begin
               estado_d = sync2_q ? c_ESPERA : c_RECEBE;
            end
         end
         c_RECEBE: begin
            if (w_fim_bit && (nbits_q == 4'd8)) begin
               estado_d = c_CHECA;
            end
         end
         c_CHECA: begin
            estado_d = (w_err_par || w_err_stop) ? c_DESCARTA : c_ARMAZENA;
         end
         c_ARMAZENA: begin
            estado_d = (w_term || w_cheio) ? c_FIM : c_ESPERA;
         end
         c_DESCARTA: begin
            // A broken stop can leave the line low; resync on idle.
            if (sync2_q) begin
               estado_d = c_ESPERA;
            end
         end
         c_FIM: begin
            estado_d = c_FIM;
         end
         default: begin
            estado_d = c_ESPERA;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // FSM outputs
   // ------------------------------------------------------------------------
   always_comb begin
      pronto    = (estado_q == c_FIM);
      db_estado = estado_q;
   end

   // ------------------------------------------------------------------------
   // Bit timer and shift register next-state
   // ------------------------------------------------------------------------
   // In INICIO the counter equals cycles elapsed since the start edge, so
   // the mid-start sample lands at T+CICLOS_BIT/2. RECEBE then restarts at 0
   // so every later sample lands a whole bit period after the previous one.
   always_comb begin
      cnt_d    = cnt_q;
      nbits_d  = nbits_q;
      desloc_d = desloc_q;
      case (estado_q)
         c_ESPERA: begin
            cnt_d   = c_CW'(1);
            nbits_d = 4'd0;
         end
         c_INICIO: begin
            if (w_meio) begin
               cnt_d   = '0;
               nbits_d = 4'd0;
            end else begin
               cnt_d = cnt_q + c_CW'(1);
            end
         end
         c_RECEBE: begin
            if (w_fim_bit) begin
               cnt_d    = '0;
               nbits_d  = nbits_q + 4'd1;
               desloc_d = {sync2_q, desloc_q[8:1]};
            end else begin
               cnt_d = cnt_q + c_CW'(1);
            end
         end
         default: begin
            cnt_d = cnt_q;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Bit timer and shift register storage
   // ------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset || limpa) begin
         cnt_q    <= '0;
         nbits_q  <= 4'd0;
         desloc_q <= '0;
      end else begin
         cnt_q    <= cnt_d;
         nbits_q  <= nbits_d;
         desloc_q <= desloc_d;
      end
   end

   // ------------------------------------------------------------------------
   // Message buffer and error flag next-state
   // ------------------------------------------------------------------------
   always_comb begin
      dados_d = dados_q;
      num_d   = num_q;
      perr_d  = perr_q;
      serr_d  = serr_q;
      if (estado_q == c_CHECA) begin
         if (w_err_par) begin
            perr_d = 1'b1;
         end
         if (w_err_stop) begin
            serr_d = 1'b1;
         end
      end
      if (estado_q == c_ARMAZENA) begin
         for (int i = 0; i < N_CHARS; i++) begin
            if (num_q == 4'(i)) begin
               dados_d[7*i +: 7] = desloc_q[6:0];
            end
         end
         num_d = num_q + 4'd1;
      end
   end

   // ------------------------------------------------------------------------
   // Message buffer and error flag storage
   // ------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset || limpa) begin
         dados_q <= '0;
         num_q   <= 4'd0;
         perr_q  <= 1'b0;
         serr_q  <= 1'b0;
      end else begin
         dados_q <= dados_d;
         num_q   <= num_d;
         perr_q  <= perr_d;
         serr_q  <= serr_d;
      end
   end

   assign dados_ascii    = dados_q;
   assign num_caracteres = num_q;
   assign erro_paridade  = perr_q;
   assign erro_parada    = serr_q;

endmodule
`default_nettype wire

// File: tb/tb_receptor_ascii.sv
`default_nettype none
// ============================================================================
//  Module      : tb_receptor_ascii
//  Description : Directed self-checking bench for receptor_ascii.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_receptor_ascii;

   localparam int CB = 16;
   localparam int NC = 8;

   logic              clock = 1'b0;
   logic              reset;
   logic              entrada_serial;
   logic              limpa;
   logic [7*NC-1:0]   dados_ascii;
   logic [3:0]        num_caracteres;
   logic              pronto;
   logic              erro_paridade;
   logic              erro_parada;
   logic [3:0]        db_estado;

   int n_chk  = 0;
   int n_fail = 0;

   logic [63:0] exp_dados;

   always #5 clock = ~clock;

   receptor_ascii #(
      .CICLOS_BIT (CB),
      .N_CHARS    (NC),
      .TERMINADOR (7'h23)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .entrada_serial (entrada_serial),
      .limpa          (limpa),
      .dados_ascii    (dados_ascii),
      .num_caracteres (num_caracteres),
      .pronto         (pronto),
      .erro_paridade  (erro_paridade),
      .erro_parada    (erro_parada),
      .db_estado      (db_estado)
   );

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic bit_time(input logic v);
      entrada_serial = v;
      repeat (CB) tick();
   endtask

   task automatic send_frame(input logic [6:0] c, input logic par_bad, input logic stop_bad);
      bit_time(1'b0);
      for (int i = 0; i < 7; i++) bit_time(c[i]);
      bit_time((^c) ^ par_bad);
      bit_time(!stop_bad);
      if (stop_bad) begin
         for (int i = 0; i < 3; i++) bit_time(1'b0);
      end
      bit_time(1'b1);
      bit_time(1'b1);
   endtask

   task automatic send_str(input string s);
      byte b;
      for (int i = 0; i < s.len(); i++) begin
         b = s[i];
         send_frame(b[6:0], 1'b0, 1'b0);
      end
   endtask

   task automatic pulse_limpa();
      limpa = 1'b1;
      tick();
      limpa = 1'b0;
      check_val("limpa_num",    {60'd0, num_caracteres}, 64'd0);
      check_val("limpa_dados",  {8'd0, dados_ascii}, 64'd0);
      check_val("limpa_pronto", {63'd0, pronto}, 64'd0);
      check_val("limpa_flags",  {62'd0, erro_paridade, erro_parada}, 64'd0);
   endtask

   initial begin
      reset          = 1'b1;
      limpa          = 1'b0;
      entrada_serial = 1'b1;
      repeat (3) tick();
      check_val("rst_dados",  {8'd0, dados_ascii}, 64'd0);
      check_val("rst_num",    {60'd0, num_caracteres}, 64'd0);
      check_val("rst_pronto", {63'd0, pronto}, 64'd0);
      check_val("rst_flags",  {62'd0, erro_paridade, erro_parada}, 64'd0);
      check_val("rst_estado", {60'd0, db_estado}, 64'd0);
      reset = 1'b0;
      repeat (4) tick();

      // Full message with terminator as the 8th character
      send_str("147,297#");
      exp_dados = {8'd0, 7'h23, 7'h37, 7'h39, 7'h32, 7'h2C, 7'h37, 7'h34, 7'h31};
      check_val("c1_pronto", {63'd0, pronto}, 64'd1);
      check_val("c1_num",    {60'd0, num_caracteres}, 64'd8);
      check_val("c1_dados",  {8'd0, dados_ascii}, exp_dados);
      check_val("c1_flags",  {62'd0, erro_paridade, erro_parada}, 64'd0);
      check_val("c1_estado", {60'd0, db_estado}, 64'd6);

      // Frames while pronto=1 are ignored
      send_str("9#");
      check_val("c6_hold_dados", {8'd0, dados_ascii}, exp_dados);
      check_val("c6_hold_num",   {60'd0, num_caracteres}, 64'd8);
      check_val("c6_hold_flags", {62'd0, erro_paridade, erro_parada}, 64'd0);

      pulse_limpa();
      send_str("9#");
      check_val("c6_num",    {60'd0, num_caracteres}, 64'd2);
      check_val("c6_dados",  {8'd0, dados_ascii}, {50'd0, 7'h23, 7'h39});
      check_val("c6_pronto", {63'd0, pronto}, 64'd1);

      // Short message
      pulse_limpa();
      send_str("1");
      check_val("c2_mid_pronto", {63'd0, pronto}, 64'd0);
      check_val("c2_mid_num",    {60'd0, num_caracteres}, 64'd1);
      send_str("2#");
      check_val("c2_pronto", {63'd0, pronto}, 64'd1);
      check_val("c2_num",    {60'd0, num_caracteres}, 64'd3);
      check_val("c2_dados",  {8'd0, dados_ascii}, {43'd0, 7'h23, 7'h32, 7'h31});

      // Parity error discards the frame
      pulse_limpa();
      send_frame(7'h41, 1'b1, 1'b0);
      check_val("c3_perr",   {63'd0, erro_paridade}, 64'd1);
      check_val("c3_serr",   {63'd0, erro_parada}, 64'd0);
      check_val("c3_discard",{60'd0, num_caracteres}, 64'd0);
      send_str("A#");
      check_val("c3_num",    {60'd0, num_caracteres}, 64'd2);
      check_val("c3_dados",  {8'd0, dados_ascii}, {50'd0, 7'h23, 7'h41});
      check_val("c3_pronto", {63'd0, pronto}, 64'd1);
      check_val("c3_perr_sticky", {63'd0, erro_paridade}, 64'd1);

      // Stop error with line held low, then recovery
      pulse_limpa();
      send_frame(7'h35, 1'b0, 1'b1);
      check_val("c4_serr",   {63'd0, erro_parada}, 64'd1);
      check_val("c4_perr",   {63'd0, erro_paridade}, 64'd0);
      check_val("c4_discard",{60'd0, num_caracteres}, 64'd0);
      send_str("5");
      check_val("c4_mid_num", {60'd0, num_caracteres}, 64'd1);
      send_str("#");
      check_val("c4_num",    {60'd0, num_caracteres}, 64'd2);
      check_val("c4_dados",  {8'd0, dados_ascii}, {50'd0, 7'h23, 7'h35});
      check_val("c4_pronto", {63'd0, pronto}, 64'd1);

      // Glitch rejection, then reset mid-frame
      pulse_limpa();
      send_str("7");
      entrada_serial = 1'b0;
      repeat (CB/4) tick();
      check_val("c5_inicio", {60'd0, db_estado}, 64'd1);
      entrada_serial = 1'b1;
      repeat (CB) tick();
      check_val("c5_glitch_estado", {60'd0, db_estado}, 64'd0);
      check_val("c5_glitch_num",    {60'd0, num_caracteres}, 64'd1);
      check_val("c5_glitch_flags",  {62'd0, erro_paridade, erro_parada}, 64'd0);
      entrada_serial = 1'b0;
      repeat (CB) tick();
      entrada_serial = 1'b1;
      repeat (10) tick();
      check_val("c5_recebe", {60'd0, db_estado}, 64'd2);
      reset = 1'b1;
      tick();
      check_val("c5_rst_dados",  {8'd0, dados_ascii}, 64'd0);
      check_val("c5_rst_num",    {60'd0, num_caracteres}, 64'd0);
      check_val("c5_rst_estado", {60'd0, db_estado}, 64'd0);
      reset = 1'b0;
      repeat (3 * CB) tick();
      check_val("c5_after_num", {60'd0, num_caracteres}, 64'd0);

      // Buffer full without terminator
      send_str("ABCDEFGH");
      check_val("full_pronto", {63'd0, pronto}, 64'd1);
      check_val("full_num",    {60'd0, num_caracteres}, 64'd8);
      check_val("full_dados",  {8'd0, dados_ascii},
                {8'd0, 7'h48, 7'h47, 7'h46, 7'h45, 7'h44, 7'h43, 7'h42, 7'h41});

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
